// File: rtl/dv_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dv_ser_pkg
//  Description : Shared types and helpers for the serial-to-parallel slice.
//                Provides the output-buffer state type, the default word
//                width and a helper that packs an in-order bit list into a
//                word (first bit -> bit 0).
//  Revision    : 1.0  initial release
// ============================================================================
package dv_ser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Output holding buffer state: EMPTY (no word presented) or HOLD.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } out_state_e;

    // Packs bits given in arrival order into a word, first bit at LSB.
    function automatic logic [DEFAULT_WIDTH-1:0] bits_to_word(
        input logic bits_in[DEFAULT_WIDTH]
    );
        logic [DEFAULT_WIDTH-1:0] word;
        word = '0;
        for (int i = 0; i < DEFAULT_WIDTH; i++) begin
            word[i] = bits_in[i];
        end
        return word;
    endfunction

endpackage : dv_ser_pkg
`default_nettype wire

// File: rtl/bit_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_deserializer
//  Description : Collects one qualified serial bit per cycle (LSB first) into
//                a WIDTH-bit word and presents completed words on a
//                valid/ready interface through a one-deep holding buffer.
//                A word completing while the buffer is full and not being
//                drained is dropped and raises a sticky overflow flag.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                ser_valid     - ser_bit/ser_sof qualified this cycle
//                ser_bit       - serial data bit
//                ser_sof       - start of frame (restarts the word)
//                par_valid     - par_data holds a complete word
//                par_ready     - consumer accepts the presented word
//                par_data      - assembled word, LSB = first bit received
//                bit_count     - bits in the current partial word
//                overflow      - sticky dropped-word flag
//                clear_ovf     - clears overflow (a same-cycle set wins)
//  Revision    : 1.0  initial release
// ============================================================================
module bit_deserializer
    import dv_ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_bit,
    input  logic             ser_sof,
    output logic             par_valid,
    input  logic             par_ready,
    output logic [WIDTH-1:0] par_data,
    output logic [CNT_W-1:0] bit_count,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam logic [CNT_W-1:0] c_last_pos = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_count;
    out_state_e       r_state;
    logic [WIDTH-1:0] r_par_data;
    logic             r_ovf;

    logic [CNT_W-1:0] w_pos;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_drop;

    // An SOF bit restarts the word: the partial word is discarded and the
    // SOF bit itself lands at position 0. Since WIDTH >= 2, an SOF bit can
    // never complete a word.
    always_comb begin
        w_pos         = ser_sof ? '0 : r_count;
        w_word        = ser_sof ? '0 : r_shift;
        w_word[w_pos] = ser_bit;
        w_complete    = ser_valid && (w_pos == c_last_pos);
        w_count_nxt   = w_complete ? '0 : (w_pos + CNT_W'(1));
        // Drop only when the held word is not being consumed this cycle.
        w_drop        = w_complete && (r_state == HOLD) && !par_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_count    <= '0;
            r_state    <= EMPTY;
            r_par_data <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (ser_valid) begin
                r_count <= w_count_nxt;
                // Clearing on completion keeps the next word's unwritten
                // positions at zero while it is being assembled.
                r_shift <= w_complete ? '0 : w_word;
            end

            case (r_state)
                EMPTY: begin
                    // par_ready is ignored while nothing is presented.
                    if (w_complete) begin
                        r_par_data <= w_word;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (par_ready) begin
                        if (w_complete) begin
                            r_par_data <= w_word;   // back-to-back, no bubble
                        end else begin
                            r_state    <= EMPTY;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign par_valid = (r_state == HOLD);
    assign par_data  = r_par_data;
    assign bit_count = r_count;
    assign overflow  = r_ovf;

endmodule : bit_deserializer
`default_nettype wire

// File: tb/tb_bit_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_deserializer
//  Description : Self-checking bench for bit_deserializer. A behavioural
//                model keeps the accepted bits of the current word in a
//                queue, a held-word slot and an overflow flag; directed
//                scenarios and a randomized stream are compared against it
//                and against hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bit_deserializer;
    import dv_ser_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             ser_valid;
    logic             ser_bit;
    logic             ser_sof;
    logic             par_valid;
    logic             par_ready;
    logic [WIDTH-1:0] par_data;
    logic [CNT_W-1:0] bit_count;
    logic             overflow;
    logic             clear_ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic             m_bits[$];
    logic             m_held;
    logic [WIDTH-1:0] m_word;
    logic             m_ovf;

    bit_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_sof   (ser_sof),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .par_data  (par_data),
        .bit_count (bit_count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    // Model: advance by one clock edge given the inputs present at that edge.
    task automatic model_edge(input logic r, v, b, s, rdy, clr);
        logic             done;
        logic             arr[WIDTH];
        logic [WIDTH-1:0] new_word;
        logic             set_ovf;
        done     = 1'b0;
        set_ovf  = 1'b0;
        new_word = '0;
        if (r) begin
            m_bits.delete();
            m_held = 1'b0;
            m_word = '0;
            m_ovf  = 1'b0;
        end else begin
            if (v) begin
                if (s) m_bits.delete();
                m_bits.push_back(b);
                if (m_bits.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) arr[i] = m_bits[i];
                    new_word = bits_to_word(arr);
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            if (m_held) begin
                if (rdy) begin
                    if (done) m_word = new_word;
                    else      m_held = 1'b0;
                end else if (done) begin
                    set_ovf = 1'b1;
                end
            end else if (done) begin
                m_held = 1'b1;
                m_word = new_word;
            end
            if (set_ovf)  m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    endtask

    // One clock: drive inputs, update model at the edge, settle 1 time unit.
    task automatic step(input logic v, b, s, rdy, clr, input logic r = 1'b0);
        rst       = r;
        ser_valid = v;
        ser_bit   = b;
        ser_sof   = s;
        par_ready = rdy;
        clear_ovf = clr;
        @(posedge clk);
        model_edge(r, v, b, s, rdy, clr);
        #1;
    endtask

    // Sends a full word LSB first; clr is applied only on the final bit.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy,
                             input logic clr_last = 1'b0);
        for (int i = 0; i < WIDTH; i++)
            step(1'b1, w[i], 1'b0, rdy, (i == WIDTH - 1) ? clr_last : 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (par_valid !== 1'b0 || par_data !== '0 || bit_count !== '0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: valid=%b data=%h count=%0d ovf=%b, expected 0/00/0/0",
                     par_valid, par_data, bit_count, overflow);
        end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < WIDTH; i++) begin
            n_checks++;
            if (par_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL ones_early_valid: bit %0d valid=%b expected 0", i, par_valid);
            end
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        n_checks++;
        if (par_valid !== 1'b1 || par_data !== 8'hFF) begin
            n_errors++;
            $display("FAIL ones_word: valid=%b data=%h expected 1/ff", par_valid, par_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (par_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ones_one_cycle: valid=%b expected 0", par_valid);
        end
    endtask

    task automatic test_a5();
        logic pattern[WIDTH] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, pattern[i], 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (bit_count !== CNT_W'((i + 1) % WIDTH) || bit_count !== CNT_W'(m_bits.size())) begin
                n_errors++;
                $display("FAIL a5_count: after bit %0d count=%0d expected %0d",
                         i, bit_count, (i + 1) % WIDTH);
            end
        end
        n_checks++;
        if (par_valid !== 1'b1 || par_data !== 8'hA5) begin
            n_errors++;
            $display("FAIL a5_word: valid=%b data=%h expected 1/a5", par_valid, par_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        send_word(8'h3C, 1'b0);
        n_checks++;
        if (par_valid !== 1'b1 || par_data !== 8'h3C || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_first: valid=%b data=%h ovf=%b expected 1/3c/0",
                     par_valid, par_data, overflow);
        end
        send_word(8'hC3, 1'b0);
        n_checks++;
        if (par_valid !== 1'b1 || par_data !== 8'h3C || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_drop: valid=%b data=%h ovf=%b expected 1/3c/1",
                     par_valid, par_data, overflow);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (par_valid !== 1'b0 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_consume: valid=%b ovf=%b expected 0/1", par_valid, overflow);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
        end
        send_word(8'h5A, 1'b0);
        send_word(8'h96, 1'b0, 1'b1);   // clear coincides with a new drop
        n_checks++;
        if (overflow !== 1'b1 || par_data !== 8'h5A) begin
            n_errors++;
            $display("FAIL ovf_set_wins: ovf=%b data=%h expected 1/5a", overflow, par_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || par_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_drain: ovf=%b valid=%b expected 0/0", overflow, par_valid);
        end
    endtask

    task automatic test_sof();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bit_count !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL sof_count: count=%0d expected 1", bit_count);
        end
        for (int i = 0; i < WIDTH - 1; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (par_valid !== 1'b1 || par_data !== 8'h01 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL sof_word: valid=%b data=%h ovf=%b expected 1/01/0",
                     par_valid, par_data, overflow);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] words[3] = '{8'h11, 8'h22, 8'h33};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                step(1'b1, words[k][i], 1'b0, (i == WIDTH - 1), 1'b0);
                if (k > 0 || i == WIDTH - 1) begin
                    n_checks++;
                    if (par_valid !== 1'b1) begin
                        n_errors++;
                        $display("FAIL b2b_bubble: word %0d bit %0d valid=%b expected 1",
                                 k, i, par_valid);
                    end
                end
            end
            n_checks++;
            if (par_data !== words[k] || overflow !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_word: word %0d data=%h ovf=%b expected %h/0",
                         k, par_data, overflow, words[k]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] w;
        send_word(WIDTH'($urandom), 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (par_valid !== 1'b0 || bit_count !== '0 || par_data !== '0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid: valid=%b count=%0d data=%h ovf=%b expected 0/0/00/0",
                     par_valid, bit_count, par_data, overflow);
        end
        w = WIDTH'($urandom);
        send_word(w, 1'b0);
        n_checks++;
        if (par_valid !== 1'b1 || par_data !== w || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_fresh: valid=%b data=%h ovf=%b expected 1/%h/0",
                     par_valid, par_data, overflow, w);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 199) == 0));
            n_checks++;
            if (par_valid !== m_held || bit_count !== CNT_W'(m_bits.size()) ||
                overflow !== m_ovf || (m_held && par_data !== m_word)) begin
                n_errors++;
                $display("FAIL random[%0d]: valid=%b count=%0d ovf=%b data=%h expected %b/%0d/%b/%h",
                         n, par_valid, bit_count, overflow, par_data,
                         m_held, m_bits.size(), m_ovf, m_word);
            end
        end
    endtask

    initial begin
        rst = 1'b1; ser_valid = 1'b0; ser_bit = 1'b0; ser_sof = 1'b0;
        par_ready = 1'b0; clear_ovf = 1'b0;
        m_held = 1'b0; m_word = '0; m_ovf = 1'b0;
        test_reset();
        test_all_ones();
        test_a5();
        test_overflow();
        test_sof();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bit_deserializer
`default_nettype wire

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
- Serial-to-parallel collector: accepts one qualified bit per cycle, LSB first, and assembles a WIDTH-bit word.
- Word-level path is the inverse of vector-to-bit extraction: accepted bit 0 lands in par_data[0].
- Completed words are presented on a valid/ready output through a one-deep holding buffer; a word that finishes while the buffer is still occupied is counted as overflow.
- Sits between a serial bit source (bench driver or link model) and word-level consumers in the practice environment.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- ser_valid  input  1  ser_bit is qualified this cycle.
- ser_bit  input  1  serial data bit; ignored when ser_valid=0.
- ser_sof  input  1  start of frame; only meaningful with ser_valid=1.
- par_valid  output  1  par_data holds a complete word.
- par_ready  input  1  consumer accepts the word.
- par_data  output  WIDTH  assembled word, LSB = first bit received.
- bit_count  output  CNT_W  number of bits in the current partial word.
- overflow  output  1  sticky flag: a completed word was dropped.
- clear_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst=1 at posedge) sets par_valid=0, par_data=0, bit_count=0, internal shift register=0, overflow=0, and output state=EMPTY.
- Reset mid-word discards the partial word and any held word. No flag is raised.
- Accept: a bit is accepted when ser_valid=1. The bit is written to shift position bit_count, then bit_count increments.
- SOF: ser_valid=1 with ser_sof=1 discards the partial word without raising a flag. The sof bit becomes bit 0 of the new word and bit_count becomes 1.
- Completion: accepting the bit at position WIDTH-1 completes the word, and bit_count wraps to 0. The same applies to an SOF bit when WIDTH=1 is impossible, since WIDTH >= 2.
- Output state machine:
  - EMPTY: on completion, load par_data and go to HOLD. par_valid=1 from the cycle after the final bit is accepted (latency 1).
  - HOLD: par_valid=1, and par_data stays stable until the handshake.
    - par_ready=1 with no completion: go to EMPTY, par_valid=0 next cycle.
    - par_ready=1 and completion in the same cycle: load the new word and stay in HOLD. This gives back-to-back words with no bubble and no overflow.
    - par_ready=0 and completion: drop the new word, keep the old one, overflow=1 next cycle.
- par_ready while EMPTY is ignored.
- overflow stays set until clear_ovf=1. If set and clear occur in the same cycle, set wins.
- Serial input is never back-pressured; the block always accepts bits.
- bit_count is visible combinationally from its register and reflects bits accepted so far in the current word.

Decomposition:
- Package dv_ser_pkg holds:
  - out_state_e enum {EMPTY, HOLD};
  - DEFAULT_WIDTH = 8;
  - a function bits_to_word used by bench scoreboards.
- No sub-module. The shift register, counter and output FSM live in one module, about 150 lines.

Test Plan:
- Reset, then 8 bits all 1 with par_ready=1 -> par_data=8'hFF, par_valid=1 for exactly one cycle, starting the cycle after the 8th bit.
- Bits 1,0,1,0,0,1,0,1 in that order -> par_data=8'hA5, bit_count goes 1..7 then 0.
- par_ready=0, send 0x3C then 0xC3 -> par_data holds 0x3C, 0xC3 is dropped, overflow=1. Then raise par_ready -> 0x3C consumed. Pulse clear_ovf -> overflow=0. Pulse clear_ovf in the same cycle as a new drop -> overflow stays 1.
- Send 3 bits, then an SOF bit=1 followed by 7 bits 0 -> par_data=8'h01, bit_count=1 after the SOF bit, and no overflow.
- Continuous ser_valid=1 streaming 0x11, 0x22, 0x33, with par_ready asserted on each completion cycle -> three words delivered back-to-back with no overflow.
- Assert rst after 5 bits while a word is held -> par_valid=0, bit_count=0, par_data=0. The following 8 bits form a fresh word.
